// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake and ALU datapath bundle for alu_op_sequencer.
// The sequencer takes the slave view; dispatch plus the ALU take the master view.
interface alu_op_sequencer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic [3:0]            req_op;
   logic [DATA_WIDTH-1:0] req_a;
   logic [DATA_WIDTH-1:0] req_b;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_cout;
   logic                  rsp_err;

   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [7:0]            alu_ctrl;
   logic                  alu_cin;
   logic                  alu_out_en;
   logic [DATA_WIDTH-1:0] alu_out;
   logic                  alu_cout;

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_cout,
      output req_ready, rsp_valid, rsp_data, rsp_cout, rsp_err,
             alu_a, alu_b, alu_ctrl, alu_cin, alu_out_en
   );

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_cout,
      input  req_ready, rsp_valid, rsp_data, rsp_cout, rsp_err,
             alu_a, alu_b, alu_ctrl, alu_cin, alu_out_en
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue-side controller for a combinational ALU: opcode decode, persistent carry
// flag for ADC, and a DATA_WIDTH-cycle shift-add multiply through the ALU adder.
module alu_op_sequencer #(
   parameter int DATA_WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   alu_op_sequencer_if.slave  bus
);
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_ADC  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_NOT  = 4'd6;
   localparam logic [3:0] OP_NAND = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;

   localparam logic [7:0] CTRL_ADD  = 8'h2C;
   localparam logic [7:0] CTRL_SUB  = 8'hAC;
   localparam logic [7:0] CTRL_AND  = 8'h22;
   localparam logic [7:0] CTRL_OR   = 8'h32;
   localparam logic [7:0] CTRL_XOR  = 8'h12;
   localparam logic [7:0] CTRL_NOT  = 8'h52;
   localparam logic [7:0] CTRL_NAND = 8'h23;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_MUL,
      S_ERR,
      S_RESP
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  carry_q, carry_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_cout_q, rsp_cout_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [DATA_WIDTH-1:0] alu_a_c;
   logic [DATA_WIDTH-1:0] alu_b_c;
   logic [7:0]            alu_ctrl_c;
   logic                  alu_cin_c;
   logic                  alu_out_en_c;
   logic                  is_add_op;

   assign is_add_op = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADC);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_cout_q <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         carry_q    <= carry_d;
         rsp_data_q <= rsp_data_d;
         rsp_cout_q <= rsp_cout_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // During MUL, a_q holds the shifting multiplicand and b_q the shifting multiplier.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      carry_d    = carry_q;
      rsp_data_d = rsp_data_q;
      rsp_cout_d = rsp_cout_q;
      rsp_err_d  = rsp_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               op_d  = bus.req_op;
               a_d   = bus.req_a;
               b_d   = bus.req_b;
               acc_d = '0;
               cnt_d = '0;
               if (bus.req_op <= OP_NAND) begin
                  state_d = S_EXEC;
               end else if (bus.req_op == OP_MUL) begin
                  state_d = S_MUL;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_EXEC: begin
            rsp_data_d = bus.alu_out;
            rsp_err_d  = 1'b0;
            if (is_add_op) begin
               rsp_cout_d = bus.alu_cout;
               carry_d    = bus.alu_cout;
            end else begin
               rsp_cout_d = 1'b0;
            end
            state_d = S_RESP;
         end
         S_MUL: begin
            acc_d = bus.alu_out;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
               rsp_data_d = bus.alu_out;
               rsp_cout_d = 1'b0;
               rsp_err_d  = 1'b0;
               state_d    = S_RESP;
            end
         end
         S_ERR: begin
            rsp_data_d = '0;
            rsp_cout_d = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The ALU bus is only driven in EXEC/MUL; everywhere else it rests at zero.
   always_comb begin
      alu_a_c      = '0;
      alu_b_c      = '0;
      alu_ctrl_c   = '0;
      alu_cin_c    = 1'b0;
      alu_out_en_c = 1'b0;

      if (state_q == S_EXEC) begin
         alu_out_en_c = 1'b1;
         alu_a_c      = a_q;
         alu_b_c      = b_q;
         unique case (op_q)
            OP_ADD:  alu_ctrl_c = CTRL_ADD;
            OP_SUB: begin
               alu_a_c    = b_q;
               alu_b_c    = a_q;
               alu_ctrl_c = CTRL_SUB;
            end
            OP_ADC: begin
               alu_ctrl_c = CTRL_ADD;
               alu_cin_c  = carry_q;
            end
            OP_AND:  alu_ctrl_c = CTRL_AND;
            OP_OR:   alu_ctrl_c = CTRL_OR;
            OP_XOR:  alu_ctrl_c = CTRL_XOR;
            OP_NOT: begin
               alu_b_c    = '0;
               alu_ctrl_c = CTRL_NOT;
            end
            OP_NAND: alu_ctrl_c = CTRL_NAND;
            default: begin
               alu_out_en_c = 1'b0;
               alu_a_c      = '0;
               alu_b_c      = '0;
            end
         endcase
      end else if (state_q == S_MUL) begin
         alu_out_en_c = 1'b1;
         alu_a_c      = acc_q;
         alu_b_c      = b_q[0] ? a_q : '0;
         alu_ctrl_c   = CTRL_ADD;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.rsp_valid  = (state_q == S_RESP);
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_cout   = rsp_cout_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.alu_a      = alu_a_c;
   assign bus.alu_b      = alu_b_c;
   assign bus.alu_ctrl   = alu_ctrl_c;
   assign bus.alu_cin    = alu_cin_c;
   assign bus.alu_out_en = alu_out_en_c;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU decoding the
// control words; expected results are hand-computed constants.
module tb_alu_op_sequencer;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec = 0;
   int   n_miss = 0;

   alu_op_sequencer_if #(.DATA_WIDTH(DW)) bus ();

   alu_op_sequencer #(.DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ALU; logic ops report the raw a+b carry so the sequencer must mask it.
   logic [DW:0] sum_ab;
   logic [DW:0] sum_t;
   always_comb begin
      sum_ab = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      sum_t  = '0;
      bus.alu_out  = '0;
      bus.alu_cout = 1'b0;
      case (bus.alu_ctrl)
         8'h2C: begin
            sum_t = sum_ab + {{DW{1'b0}}, bus.alu_cin};
            bus.alu_out  = sum_t[DW-1:0];
            bus.alu_cout = sum_t[DW];
         end
         8'hAC: begin
            sum_t = {1'b0, ~bus.alu_a} + {1'b0, bus.alu_b} + 1;
            bus.alu_out  = sum_t[DW-1:0];
            bus.alu_cout = sum_t[DW];
         end
         8'h22: begin bus.alu_out = bus.alu_a & bus.alu_b;    bus.alu_cout = sum_ab[DW]; end
         8'h32: begin bus.alu_out = bus.alu_a | bus.alu_b;    bus.alu_cout = sum_ab[DW]; end
         8'h12: begin bus.alu_out = bus.alu_a ^ bus.alu_b;    bus.alu_cout = sum_ab[DW]; end
         8'h52: begin bus.alu_out = ~bus.alu_a;               bus.alu_cout = sum_ab[DW]; end
         8'h23: begin bus.alu_out = ~(bus.alu_a & bus.alu_b); bus.alu_cout = sum_ab[DW]; end
         default: begin end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Called at a negedge; ends at the negedge following the response transfer.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_d, input logic exp_c,
                         input logic exp_e, input int exp_lat, input int hold);
      int   lat;
      logic en_seen;
      check({tag, "_req_ready"}, bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = (hold == 0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = 0;
      en_seen = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.alu_out_en) en_seen = 1'b1;
      end while (!bus.rsp_valid && lat < 40);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_data"}, bus.rsp_data, exp_d);
      check({tag, "_cout"}, bus.rsp_cout, exp_c);
      check({tag, "_err"}, bus.rsp_err, exp_e);
      if (exp_e) check({tag, "_alu_en_seen"}, en_seen, 0);
      for (int i = 0; i < hold; i++) begin
         bus.req_valid = 1'b1;
         bus.req_op    = 4'd0;
         bus.req_a     = 16'hDEAD;
         bus.req_b     = 16'hBEEF;
         @(negedge clk);
         check({tag, "_hold_valid"}, bus.rsp_valid, 1);
         check({tag, "_hold_data"}, bus.rsp_data, exp_d);
         check({tag, "_hold_req_ready"}, bus.req_ready, 0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_after_valid"}, bus.rsp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      reset_n       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_rsp_cout", bus.rsp_cout, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_alu_en", bus.alu_out_en, 0);
      check("rst_alu_ctrl", bus.alu_ctrl, 0);

      run_op("add_wrap",  4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 2, 0);
      run_op("adc_carry", 4'd2, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 2, 0);
      run_op("sub_neg",   4'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 2, 0);
      run_op("sub_pos",   4'd1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0, 2, 0);
      run_op("and",       4'd3, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 2, 0);
      run_op("or",        4'd4, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0, 2, 0);
      run_op("xor",       4'd5, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 2, 0);
      run_op("nand",      4'd7, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0, 2, 0);
      run_op("not",       4'd6, 16'h1234, 16'h5555, 16'hEDCB, 1'b0, 1'b0, 2, 0);
      run_op("mul_small", 4'd8, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0, 17, 0);
      run_op("mul_max",   4'd8, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17, 0);
      // carry set by SUB 7-5 must survive logic ops and both multiplies
      run_op("adc_after_mul", 4'd2, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 2, 0);
      run_op("add_bp",    4'd0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 2, 5);
      run_op("xor_post_bp", 4'd5, 16'hAAAA, 16'h0F0F, 16'hA5A5, 1'b0, 1'b0, 2, 0);
      run_op("illegal_b", 4'hB, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 2, 0);
      run_op("add_setc",  4'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 2, 0);

      // reset in the middle of a multiply
      check("mulrst_req_ready", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_op    = 4'd8;
      bus.req_a     = 16'h0123;
      bus.req_b     = 16'h0010;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("mulrst_busy", bus.alu_out_en, 1);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mulrst_rsp_valid", bus.rsp_valid, 0);
      check("mulrst_rsp_data", bus.rsp_data, 0);
      check("mulrst_rsp_cout", bus.rsp_cout, 0);
      check("mulrst_rsp_err", bus.rsp_err, 0);
      check("mulrst_req_ready", bus.req_ready, 1);
      check("mulrst_alu_en", bus.alu_out_en, 0);
      check("mulrst_alu_a", bus.alu_a, 0);
      check("mulrst_alu_b", bus.alu_b, 0);
      check("mulrst_alu_ctrl", bus.alu_ctrl, 0);
      check("mulrst_alu_cin", bus.alu_cin, 0);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      check("mulrst_no_rsp", seen, 0);
      run_op("adc_post_rst", 4'd2, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 2, 0);
      run_op("add_post_rst", 4'd0, 16'h0005, 16'h0006, 16'h000B, 1'b0, 1'b0, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
